// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the camera capture sequencer
package cam_pkg;

  localparam int CAM_WORD_W    = 16;
  localparam int CAM_ADDR_STEP = 2;

  typedef enum logic [2:0] {
    CAP_IDLE    = 3'd0,
    CAP_ARM     = 3'd1,
    CAP_CAPTURE = 3'd2,
    CAP_DRAIN   = 3'd3,
    CAP_DONE    = 3'd4
  } cap_state_e;

endpackage

// File: rtl/cam_capture_sequencer_if.sv
// rtl/cam_capture_sequencer_if.sv - Avalon-MM write master bundle for the frame writer
interface cam_avm_if
  import cam_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_write;
  logic [CAM_WORD_W-1:0] avm_writedata;
  logic                  avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    output avm_waitrequest
  );

endinterface

// File: rtl/cam_pix_fifo.sv
// rtl/cam_pix_fifo.sv - small synchronous show-ahead FIFO for pixel words
module cam_pix_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on the registered count, so a push into a full FIFO
  // is dropped even when a pop frees a slot in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cam_capture_sequencer.sv
// rtl/cam_capture_sequencer.sv - frame capture sequencer writing camera words to memory
module cam_capture_sequencer
  import cam_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 20
) (
  input  logic                  PCLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  CamVsync,
  input  logic [CAM_WORD_W-1:0] CamData_in,
  input  logic                  CamData_enable,
  cam_avm_if.master             avm,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  aborted,
  output logic                  overflow,
  output logic [CNT_W-1:0]      words_written
);

  cap_state_e            state;
  logic                  vsync_d;
  logic                  vsync_fall;
  logic                  vsync_rise;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CAM_WORD_W-1:0] fifo_head;
  logic                  accept;

  assign vsync_fall = vsync_d && !CamVsync;
  assign vsync_rise = !vsync_d && CamVsync;

  // Words are only taken while a frame is being captured, including the
  // cycle on which the frame ends or is aborted.
  assign fifo_push = (state == CAP_CAPTURE) && CamData_enable;

  // The master drains the FIFO in every state; address/data come straight
  // from registers, so they stay stable across waitrequest.
  assign avm.avm_write     = !fifo_empty;
  assign avm.avm_writedata = fifo_head;
  assign avm.avm_address   = wr_addr;
  assign accept            = avm.avm_write && !avm.avm_waitrequest;

  assign busy       = (state != CAP_IDLE);
  assign frame_done = (state == CAP_DONE);

  cam_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CAM_WORD_W)
  ) u_fifo (
    .clk   (PCLK),
    .reset (reset),
    .push  (fifo_push),
    .pop   (accept),
    .din   (CamData_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Vsync delay for edge detection; resets high so a sensor already in
  // active video is not mistaken for a fresh frame boundary.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      vsync_d <= 1'b1;
    end else begin
      vsync_d <= CamVsync;
    end
  end

  // Capture state machine plus write address, counter and sticky flags.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      state         <= CAP_IDLE;
      wr_addr       <= '0;
      words_written <= '0;
      aborted       <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (accept) begin
        wr_addr <= wr_addr + ADDR_W'(CAM_ADDR_STEP);
        if (words_written != '1) begin
          words_written <= words_written + CNT_W'(1);
        end
      end
      if (fifo_push && fifo_full) begin
        overflow <= 1'b1;
      end

      case (state)
        CAP_IDLE: begin
          if (start) begin
            state         <= CAP_ARM;
            wr_addr       <= base_addr;
            words_written <= '0;
            aborted       <= 1'b0;
            overflow      <= 1'b0;
          end
        end
        CAP_ARM: begin
          if (abort) begin
            state <= CAP_IDLE;
          end else if (vsync_fall) begin
            state <= CAP_CAPTURE;
          end
        end
        CAP_CAPTURE: begin
          if (abort) begin
            state   <= CAP_DRAIN;
            aborted <= 1'b1;
          end else if (vsync_rise) begin
            state <= CAP_DRAIN;
          end
        end
        CAP_DRAIN: begin
          if (fifo_empty) begin
            state <= CAP_DONE;
          end
        end
        CAP_DONE: begin
          if (continuous && !abort) begin
            state         <= CAP_ARM;
            wr_addr       <= base_addr;
            words_written <= '0;
            aborted       <= 1'b0;
          end else begin
            state <= CAP_IDLE;
          end
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_sequencer.sv
// tb/tb_cam_capture_sequencer.sv - scoreboard bench for the capture sequencer
module tb_cam_capture_sequencer;
  import cam_pkg::*;

  logic        PCLK = 1'b0;
  logic        reset;
  logic        start;
  logic        continuous;
  logic        abort;
  logic [31:0] base_addr;
  logic        CamVsync;
  logic [15:0] CamData_in;
  logic        CamData_enable;
  logic        busy;
  logic        frame_done;
  logic        aborted;
  logic        overflow;
  logic [19:0] words_written;

  cam_avm_if #(.ADDR_W(32)) avm ();

  cam_capture_sequencer #(
    .ADDR_W     (32),
    .FIFO_DEPTH (8),
    .CNT_W      (20)
  ) dut (
    .PCLK           (PCLK),
    .reset          (reset),
    .start          (start),
    .continuous     (continuous),
    .abort          (abort),
    .base_addr      (base_addr),
    .CamVsync       (CamVsync),
    .CamData_in     (CamData_in),
    .CamData_enable (CamData_enable),
    .avm            (avm),
    .busy           (busy),
    .frame_done     (frame_done),
    .aborted        (aborted),
    .overflow       (overflow),
    .words_written  (words_written)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  int          fd_count    = 0;
  logic        hold_pend   = 1'b0;
  logic [31:0] hold_addr;
  logic [15:0] hold_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts frame_done pulses, checks hold-under-stall and pops the
  // scoreboard on every accepted write.
  always @(negedge PCLK) begin
    if (frame_done === 1'b1) fd_count++;
    if (hold_pend && reset === 1'b0) begin
      chk("hold_write", {31'd0, avm.avm_write}, 32'd1);
      chk("hold_addr", avm.avm_address, hold_addr);
      chk("hold_data", {16'd0, avm.avm_writedata}, {16'd0, hold_data});
    end
    hold_pend = (avm.avm_write === 1'b1) && (avm.avm_waitrequest === 1'b1) && (reset === 1'b0);
    hold_addr = avm.avm_address;
    hold_data = avm.avm_writedata;
    if (avm.avm_write === 1'b1 && avm.avm_waitrequest === 1'b0 && reset === 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                 avm.avm_address, avm.avm_writedata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", avm.avm_address, mon_e.addr);
        chk("wr_data", {16'd0, avm.avm_writedata}, {16'd0, mon_e.data});
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic expect_it, input logic [31:0] a);
    wr_t w;
    CamData_in     = d;
    CamData_enable = 1'b1;
    if (expect_it) begin
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
    end
    tick();
    CamData_enable = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got busy=%b, want 0 within 300 cycles", name, busy);
    end
  endtask

  task automatic wait_fd(input string name, input int prev);
    int n = 0;
    while (fd_count == prev && n < 300) begin
      tick();
      n++;
    end
    if (fd_count == prev) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no frame_done, want one within 300 cycles", name);
    end
  endtask

  task automatic start_frame(input logic [31:0] a);
    base_addr = a;
    CamVsync  = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    CamVsync = 1'b0;
    tick();
  endtask

  task automatic end_frame(input string name);
    CamVsync = 1'b1;
    tick();
    wait_idle(name);
  endtask

  logic [15:0] basic_words [4];
  int          f0;

  initial begin
    basic_words[0] = 16'hA1B2;
    basic_words[1] = 16'hC3D4;
    basic_words[2] = 16'hE5F6;
    basic_words[3] = 16'h0718;

    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    base_addr = 32'd0; CamVsync = 1'b1; CamData_in = 16'd0; CamData_enable = 1'b0;
    avm.avm_waitrequest = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_write", {31'd0, avm.avm_write}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_aborted", {31'd0, aborted}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_words", {12'd0, words_written}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic single frame
    f0 = fd_count;
    start_frame(32'h1000);
    for (int i = 0; i < 4; i++) send_word(basic_words[i], 1'b1, 32'h1000 + 32'(2 * i));
    end_frame("basic");
    chk("basic_frame_done", 32'(fd_count - f0), 32'd1);
    chk("basic_words", {12'd0, words_written}, 32'd4);
    chk("basic_busy", {31'd0, busy}, 32'd0);
    chk("basic_queue", 32'(exp_q.size()), 32'd0);

    // Start mid-frame: partial frame is skipped
    CamVsync = 1'b0;
    tick();
    base_addr = 32'h3000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_word(16'h5A00 + 16'(i), 1'b0, 32'd0);
    chk("mid_busy_armed", {31'd0, busy}, 32'd1);
    CamVsync = 1'b1;
    tick();
    tick();
    CamVsync = 1'b0;
    tick();
    send_word(16'h1111, 1'b1, 32'h3000);
    send_word(16'h2222, 1'b1, 32'h3002);
    end_frame("mid");
    chk("mid_words", {12'd0, words_written}, 32'd2);
    chk("mid_queue", 32'(exp_q.size()), 32'd0);

    // Backpressure: 3 words buffered under a 6-cycle stall
    start_frame(32'h4000);
    avm.avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) send_word(16'hB000 + 16'(i), 1'b1, 32'h4000 + 32'(2 * i));
    avm.avm_waitrequest = 1'b0;
    end_frame("bp");
    chk("bp_overflow", {31'd0, overflow}, 32'd0);
    chk("bp_words", {12'd0, words_written}, 32'd3);
    chk("bp_queue", 32'(exp_q.size()), 32'd0);

    // Overflow: 10 words into an 8-deep FIFO under a 20-cycle stall
    start_frame(32'h5000);
    avm.avm_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) send_word(16'hC000 + 16'(i), (i < 8), 32'h5000 + 32'(2 * i));
    avm.avm_waitrequest = 1'b0;
    end_frame("ovf");
    chk("ovf_overflow", {31'd0, overflow}, 32'd1);
    chk("ovf_words", {12'd0, words_written}, 32'd8);
    chk("ovf_queue", 32'(exp_q.size()), 32'd0);

    // Continuous: two full frames, then abort in the third capture
    f0 = fd_count;
    continuous = 1'b1;
    start_frame(32'h2000);
    for (int i = 0; i < 3; i++) send_word(16'hD000 + 16'(i), 1'b1, 32'h2000 + 32'(2 * i));
    CamVsync = 1'b1;
    tick();
    wait_fd("cont1", f0);
    CamVsync = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) send_word(16'hE000 + 16'(i), 1'b1, 32'h2000 + 32'(2 * i));
    CamVsync = 1'b1;
    tick();
    wait_fd("cont2", f0 + 1);
    chk("cont_two_done", 32'(fd_count - f0), 32'd2);
    chk("cont_busy_rearm", {31'd0, busy}, 32'd1);
    CamVsync = 1'b0;
    tick();
    avm.avm_waitrequest = 1'b1;
    send_word(16'hF000, 1'b1, 32'h2000);
    send_word(16'hF001, 1'b1, 32'h2002);
    begin
      wr_t w;
      w.addr = 32'h2004;
      w.data = 16'h3333;
      exp_q.push_back(w);
    end
    CamData_in = 16'h3333;
    CamData_enable = 1'b1;
    abort = 1'b1;
    continuous = 1'b0;
    tick();
    CamData_enable = 1'b0;
    abort = 1'b0;
    avm.avm_waitrequest = 1'b0;
    wait_idle("abort");
    chk("abort_aborted", {31'd0, aborted}, 32'd1);
    chk("abort_done_total", 32'(fd_count - f0), 32'd3);
    chk("abort_words", {12'd0, words_written}, 32'd3);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);

    // Reset during DRAIN with words still queued
    start_frame(32'h6000);
    avm.avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) send_word(16'h7700 + 16'(i), 1'b1, 32'h6000 + 32'(2 * i));
    CamVsync = 1'b1;
    tick();
    avm.avm_waitrequest = 1'b0;
    tick();
    avm.avm_waitrequest = 1'b1;
    chk("rstmid_words_before", {12'd0, words_written}, 32'd1);
    chk("rstmid_write_before", {31'd0, avm.avm_write}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rstmid_write", {31'd0, avm.avm_write}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_words", {12'd0, words_written}, 32'd0);
    chk("rstmid_queue_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    reset = 1'b0;
    avm.avm_waitrequest = 1'b0;
    repeat (4) tick();
    chk("rstmid_idle_write", {31'd0, avm.avm_write}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cam_capture_sequencer.md
Name: cam_capture_sequencer

Overview:
- Sequences one camera frame, or a continuous stream of frames, from the PCLK-domain pixel path into memory.
- Arms on command and starts capture at the first clean frame boundary (CamVsync falling edge).
- Buffers 16-bit words from the 8-to-16 converter (CamData_out / CamData_enable) in a small FIFO.
- Writes them out as an Avalon-MM master at incrementing addresses; reports busy, frame-done, overflow and word count to the register block.

Parameters:
- ADDR_W, 32, Avalon master address width.
- FIFO_DEPTH, 8, pixel FIFO depth in 16-bit words (power of 2, >=2).
- CNT_W, 20, width of the words_written counter.

Ports:
- PCLK  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; ignored unless in IDLE.
- continuous  in  1  sampled in DONE; 1 = re-arm for the next frame.
- abort  in  1  one-cycle pulse; ends the current operation.
- base_addr  in  ADDR_W  frame buffer byte address; latched on start and on each re-arm.
- CamVsync  in  1  sensor vsync, PCLK-synchronous; high = vertical blanking.
- CamData_in  in  16  word from the converter.
- CamData_enable  in  1  word valid qualifier.
- avm_address  out  ADDR_W  write byte address.
- avm_write  out  1  write request.
- avm_writedata  out  16  FIFO head word.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse per completed or aborted frame.
- aborted  out  1  sticky; last frame ended by abort.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- words_written  out  CNT_W  words accepted by the slave in the current/last frame.

Behaviour:
- Reset (synchronous): all outputs 0; state IDLE; FIFO empty; vsync_d = 1.
- vsync_d is CamVsync registered once.
  - Falling edge: vsync_d=1 && CamVsync=0.
  - Rising edge: vsync_d=0 && CamVsync=1.
- IDLE:
  - start=1 → ARM.
  - On entry to ARM: latch base_addr into wr_addr; clear overflow, aborted and words_written.
- ARM:
  - Falling edge → CAPTURE.
  - abort → IDLE; no frame_done.
  - A start that arrives mid-frame therefore skips the partial frame.
- CAPTURE:
  - Each cycle with CamData_enable=1 pushes CamData_in, unless the FIFO is full at that cycle's start.
  - A push while full drops the word and sets overflow, even if a pop occurs the same cycle.
  - Rising edge → DRAIN.
  - abort → DRAIN and set aborted.
  - The push on the transition cycle is still taken.
- DRAIN:
  - No pushes.
  - FIFO empty && avm_write=0 → DONE.
- DONE (one cycle):
  - frame_done=1.
  - continuous=1 && abort=0 → ARM; reload wr_addr from base_addr; clear words_written and aborted; overflow is kept.
  - Otherwise → IDLE.
- Master side (active in all states):
  - avm_write=1 whenever the FIFO is non-empty.
  - avm_writedata = FIFO head; avm_address = wr_addr.
  - Both are held stable while avm_waitrequest=1.
  - Accept = avm_write && !avm_waitrequest. On accept: pop; wr_addr += 2 (mod 2^ADDR_W); words_written += 1 (saturates at all-ones).
- Latency: a word pushed at edge n is presented on avm_write after edge n (FIFO output is show-ahead and registered); earliest accept is at edge n+1.
- Throughput: 1 word/cycle with waitrequest=0. The FIFO never fills, because CamData_enable is asserted at most every other cycle.
- start while busy: ignored. abort in IDLE/DONE: ignored, except that it suppresses re-arm in DONE.
- Reset mid-write drops avm_write at the next edge; the slave tolerates this.

Decomposition:
- Shared package cam_pkg:
  - state enum CAP_IDLE/CAP_ARM/CAP_CAPTURE/CAP_DRAIN/CAP_DONE;
  - CAM_WORD_W=16;
  - CAM_ADDR_STEP=2.
- One sub-module, cam_pix_fifo:
  - synchronous FIFO with show-ahead output;
  - parameters DEPTH and WIDTH;
  - ports push/pop/din/dout/full/empty;
  - synchronous active-high reset.

Test Plan:
- Basic frame:
  - Stimulus: base_addr=0x1000; start during CamVsync=1; after the falling edge, 4 words 0xA1B2, 0xC3D4, 0xE5F6, 0x0718 on alternate cycles; then CamVsync rising; waitrequest=0.
  - Required: four writes to 0x1000/1002/1004/1006 with that data; one frame_done pulse; words_written=4; busy=0 after.
- Mid-frame start:
  - Stimulus: start while CamVsync=0 with words streaming.
  - Required: no writes until the next falling edge; then capture proceeds normally.
- Backpressure:
  - Stimulus: waitrequest=1 for 6 cycles while words arrive every 2nd cycle.
  - Required: address and data held stable; no loss (3 words buffered); all written in order after release; overflow=0.
- Overflow:
  - Stimulus: FIFO_DEPTH=8; waitrequest=1 for 20 cycles with enable every 2nd cycle.
  - Required: words 9 and 10 dropped; overflow=1; words_written=8 at DONE.
- Continuous and abort:
  - Stimulus: continuous=1 over 2 frames of 3 words, base_addr=0x2000.
  - Required: both frames start at 0x2000; two frame_done pulses.
  - Follow-on stimulus: abort in the 3rd CAPTURE.
  - Required: already-buffered words are drained; aborted=1; frame_done pulses; state returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert reset during DRAIN with 2 words queued.
  - Required: next cycle avm_write=0, busy=0, words_written=0, FIFO empty.
